// File: rtl/ydemux4to1_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready input is steered by `c` into
// four independent lane FIFOs, each draining through its own valid/ready output.
module ydemux4to1_buf #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [1:0]      c,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [SIZE-1:0] z0,
  output logic [SIZE-1:0] z1,
  output logic [SIZE-1:0] z2,
  output logic [SIZE-1:0] z3,
  output logic [3:0]      lane_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [SIZE-1:0] mem_q [4][DEPTH];
  ptr_t            rd_q  [4];
  ptr_t            rd_d  [4];
  ptr_t            wr_q  [4];
  ptr_t            wr_d  [4];
  cnt_t            cnt_q [4];
  cnt_t            cnt_d [4];
  logic [SIZE-1:0] z_q   [4];
  logic [SIZE-1:0] z_d   [4];
  logic [3:0]      push;
  logic [3:0]      pop;

  always_comb begin
    out_valid = '0;
    lane_full = '0;
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (cnt_q[i] != '0);
      lane_full[i] = (cnt_q[i] == cnt_t'(DEPTH));
    end
  end

  // Handshake: a transfer happens on an edge where valid && ready. in_ready
  // depends only on `c` and the registered full flags, so a full lane refuses
  // a push even in the cycle it is being popped; the producer retries.
  assign in_ready = !lane_full[c];

  always_comb begin
    push = '0;
    if (in_valid && in_ready) push[c] = 1'b1;
  end

  assign pop = out_valid & out_ready;

  // z is a registered copy of the head so it can hold its last word once empty.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_d[i]  = rd_q[i];
      wr_d[i]  = wr_q[i];
      cnt_d[i] = cnt_q[i];
      z_d[i]   = z_q[i];
      if (push[i]) wr_d[i] = wr_q[i] + ptr_t'(1);
      if (pop[i])  rd_d[i] = rd_q[i] + ptr_t'(1);
      if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + cnt_t'(1);
      else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - cnt_t'(1);
      if (pop[i]) begin
        if (cnt_q[i] > cnt_t'(1)) z_d[i] = mem_q[i][rd_d[i]];
        else if (push[i])         z_d[i] = a;
      end else if (push[i] && cnt_q[i] == '0) begin
        z_d[i] = a;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
        z_q[i]   <= '0;
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        rd_q[i]  <= rd_d[i];
        wr_q[i]  <= wr_d[i];
        cnt_q[i] <= cnt_d[i];
        z_q[i]   <= z_d[i];
        if (push[i]) mem_q[i][wr_q[i]] <= a;
      end
    end
  end

  assign z0 = z_q[0];
  assign z1 = z_q[1];
  assign z2 = z_q[2];
  assign z3 = z_q[3];

endmodule

// File: tb/tb_ydemux4to1_buf.sv
// Directed bench for ydemux4to1_buf (SIZE=8, DEPTH=2): hand-computed vectors
// checked with immediate assertions.
module tb_ydemux4to1_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [1:0] c;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] z0, z1, z2, z3;
  logic [3:0] lane_full;

  int vectors = 0;
  int miscompares = 0;

  ydemux4to1_buf #(.SIZE(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z0        (z0),
    .z1        (z1),
    .z2        (z2),
    .z3        (z3),
    .lane_full (lane_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [1:0] lane, input logic [7:0] data);
    c        = lane;
    a        = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    c         = '0;
    out_ready = '0;

    // Reset values
    #12;
    chk("rst_in_ready",  8'(in_ready),  8'h01);
    chk("rst_out_valid", 8'(out_valid), 8'h00);
    chk("rst_lane_full", 8'(lane_full), 8'h00);
    chk("rst_z0", z0, 8'h00);
    chk("rst_z1", z1, 8'h00);
    chk("rst_z2", z2, 8'h00);
    chk("rst_z3", z3, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // First push, 1-cycle latency
    push(2'd2, 8'hA5);
    chk("first_out_valid", 8'(out_valid), 8'h04);
    chk("first_z2", z2, 8'hA5);
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    chk("first_drained", 8'(out_valid), 8'h00);
    chk("first_z2_hold", z2, 8'hA5);

    // Lane steering
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    chk("steer_out_valid", 8'(out_valid), 8'h0F);
    chk("steer_z0", z0, 8'h11);
    chk("steer_z1", z1, 8'h22);
    chk("steer_z2", z2, 8'h33);
    chk("steer_z3", z3, 8'h44);
    chk("steer_lane_full", 8'(lane_full), 8'h00);
    out_ready = 4'b1111;
    tick();
    chk("steer_drained", 8'(out_valid), 8'h00);
    tick();
    out_ready = 4'b0000;
    chk("empty_pop_ignored", 8'(out_valid), 8'h00);
    chk("empty_pop_full", 8'(lane_full), 8'h00);
    chk("empty_z0_hold", z0, 8'h11);

    // Full and back-pressure on lane 1
    push(2'd1, 8'hA0);
    push(2'd1, 8'hA1);
    chk("full_lane_full", 8'(lane_full), 8'h02);
    chk("full_z1", z1, 8'hA0);
    c = 2'd1; #1;
    chk("full_in_ready_c1", 8'(in_ready), 8'h00);
    c = 2'd0; #1;
    chk("full_in_ready_c0", 8'(in_ready), 8'h01);
    c = 2'd1; a = 8'hA2; in_valid = 1'b1; out_ready = 4'b0010; #1;
    chk("full_pop_in_ready", 8'(in_ready), 8'h00);
    tick();
    out_ready = 4'b0000;
    chk("recover_z1", z1, 8'hA1);
    chk("recover_lane_full", 8'(lane_full), 8'h00);
    chk("recover_in_ready", 8'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    chk("retry_lane_full", 8'(lane_full), 8'h02);
    chk("retry_z1", z1, 8'hA1);
    out_ready = 4'b0010;
    tick();
    chk("retry_z1_next", z1, 8'hA2);
    tick();
    out_ready = 4'b0000;
    chk("retry_drained", 8'(out_valid), 8'h00);
    chk("retry_z1_hold", z1, 8'hA2);

    // Simultaneous push/pop with pointer wrap on lane 3
    push(2'd3, 8'h00);
    out_ready = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      c = 2'd3; a = 8'(k); in_valid = 1'b1; #1;
      chk("stream_z3", z3, 8'(k - 1));
      chk("stream_valid", 8'(out_valid), 8'h08);
      chk("stream_full", 8'(lane_full), 8'h00);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 4'b0000;
    chk("stream_last_z3", z3, 8'h08);
    chk("stream_last_valid", 8'(out_valid), 8'h08);
    out_ready = 4'b1000;
    tick();
    out_ready = 4'b0000;
    chk("stream_drained", 8'(out_valid), 8'h00);

    // Independent stall: lane 0 full while lane 2 streams
    push(2'd0, 8'hB0);
    push(2'd0, 8'hB1);
    out_ready = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      c = 2'd2; a = 8'hC0 + 8'(k); in_valid = 1'b1; #1;
      if (k > 0) chk("indep_z2", z2, 8'hC0 + 8'(k - 1));
      tick();
    end
    in_valid = 1'b0;
    chk("indep_z2_last", z2, 8'hC5);
    tick();
    out_ready = 4'b0000;
    chk("indep_lane2_empty", 8'(out_valid), 8'h01);
    chk("indep_lane0_full", 8'(lane_full), 8'h01);
    chk("indep_z0", z0, 8'hB0);
    out_ready = 4'b0001;
    tick();
    chk("indep_z0_second", z0, 8'hB1);
    tick();
    out_ready = 4'b0000;
    chk("indep_lane0_empty", 8'(out_valid), 8'h00);

    // Reset mid-operation
    push(2'd0, 8'hD0);
    push(2'd2, 8'hD2);
    chk("midrst_pre_valid", 8'(out_valid), 8'h05);
    rst_n = 1'b0; #1;
    chk("midrst_valid", 8'(out_valid), 8'h00);
    chk("midrst_full", 8'(lane_full), 8'h00);
    chk("midrst_z0", z0, 8'h00);
    chk("midrst_z2", z2, 8'h00);
    chk("midrst_in_ready", 8'(in_ready), 8'h01);
    tick();
    rst_n = 1'b1;
    tick();
    c = 2'd0; a = 8'hE0; in_valid = 1'b1; #1;
    chk("nobypass_valid", 8'(out_valid), 8'h00);
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 8'(out_valid), 8'h01);
    chk("post_rst_z0", z0, 8'hE0);
    out_ready = 4'b0001;
    tick();
    out_ready = 4'b0000;
    chk("post_rst_only_word", 8'(out_valid), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ydemux4to1_buf.md
# ydemux4to1_buf

Buffered 1-to-4 demultiplexer: the distribution-side counterpart of the `yMux4to1` 4-to-1 selector. A SIZE-bit word arrives on a single valid/ready input together with a 2-bit lane select `c`. The word is steered into one of four per-lane FIFOs, and each lane drains independently through its own valid/ready output. The block sits wherever one producer feeds four consumers that may stall at different times.

## Interface

Parameters:
- `SIZE`, default 8: data width in bits.
- `DEPTH`, default 2: entries per lane FIFO. Must be a power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in_valid`, input, 1: input word and select are valid.
- `in_ready`, output, 1: the selected lane can accept this cycle.
- `a`, input, SIZE: input data word.
- `c`, input, 2: lane select; 0→`z0`, 1→`z1`, 2→`z2`, 3→`z3`.
- `out_valid`, output, 4: bit i set means lane i holds at least one word.
- `out_ready`, input, 4: bit i set means the consumer of lane i takes the head word.
- `z0`, `z1`, `z2`, `z3`, output, SIZE each: head word of lanes 0–3.
- `lane_full`, output, 4: bit i set means lane i holds DEPTH words.

## Operation

- **Push:** accept when `in_valid && in_ready`. Word `a` is written at the tail of lane `c`.
- **Ready logic:** `in_ready = !lane_full[c]`. It is combinational from `c` and registered full flags only. There is no path from `out_ready` to `in_ready`.
- **Pop:** lane i pops when `out_valid[i] && out_ready[i]`. The head advances and `zi` shows the next entry, or holds its last value if the lane empties.
- **Lane independence:** all four lanes may pop in the same cycle. The push lane may also pop in the same cycle.
- **Per-lane state:** read pointer, write pointer, and occupancy count (0..DEPTH).
  - `out_valid[i] = (count != 0)`.
  - `lane_full[i] = (count == DEPTH)`.
- **Pointers:** wrap modulo DEPTH. Count rules:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- **Boundary conditions:**
  - Full lane with pop this cycle: `in_ready` stays 0 for that lane this cycle. The push is retried the next cycle.
  - Empty lane: a push becomes visible on the next cycle, never the same cycle (no bypass).
  - `in_valid` low: `c` and `a` are don't-care; no state changes.
  - `out_ready[i]` high while lane i is empty: ignored.
- **Ordering:** words on each lane leave in arrival order. There is no ordering guarantee across lanes.
- **Reset (`rst_n` low, at any time, including mid-transfer):**
  - All pointers and counts clear to 0 and all storage clears to 0, asynchronously.
  - Outputs during reset: `out_valid`=0000, `lane_full`=0000, `z0`..`z3`=0, `in_ready`=1.
  - Words in flight are discarded.
  - Operation resumes on the first rising edge after `rst_n` returns high.

## Timing

- **Latency:** 1 cycle, from the accepting edge to `out_valid[c]` high with the word on `zc` (lane previously empty).
- **Throughput:** one word per cycle into any non-full lane. One word per cycle out of each lane.
- **Outputs:** `out_valid`, `lane_full` and `z*` are registered or storage-derived, with no combinational path from inputs.
- **`in_ready`:** combinational from `c` only.
- **Full-lane recovery:**
  - A lane that is full and popped at edge N shows `lane_full`=0 after edge N.
  - A push to it is accepted at edge N+1.
- **Handshake rule:** the producer must hold `a` and `c` stable while `in_valid` is high and `in_ready` is low. The consumer may deassert `out_ready` at any time.

## Test plan

- **Reset values:** hold `rst_n`=0 → `in_ready`=1, `out_valid`=0000, `lane_full`=0000, `z0`..`z3`=00000000. Release, push `a`=10100101 with `c`=10 → one cycle later `out_valid`=0100 and `z2`=10100101.
- **Lane steering:** push 0x11, 0x22, 0x33, 0x44 with `c`=0,1,2,3 on consecutive cycles, `out_ready`=0000 → `out_valid`=1111, `z0`=0x11, `z1`=0x22, `z2`=0x33, `z3`=0x44.
- **Full and back-pressure:** DEPTH=2, push 0xA0 then 0xA1 to lane 1 → `lane_full`=0010 and `in_ready`=0 for `c`=1 but 1 for `c`=0. Pulse `out_ready[1]` for one cycle → `z1`=0xA1, `lane_full[1]`=0, a push the following cycle is accepted.
- **Simultaneous push/pop and wrap-around:** lane 3 holds one word and streams 8 words with `out_ready[3]`=1 every cycle → count stays 1 and words exit in order 0x00..0x07 across pointer wrap, none lost.
- **Independent stall:** lane 0 is stalled full while 6 words go to lane 2 with `out_ready[2]`=1 → lane 2 output is in order. Lane 0 then drains its 2 original words intact.
- **Reset mid-operation:** with lanes 0 and 2 non-empty, assert `rst_n`=0 between edges → `out_valid` goes to 0000 immediately without a clock. After release, the first push to lane 0 appears as its only word.
